// File: rtl/mem_bus_interface.sv
// Bridges the processor memory port to an external req/ack memory with a bounded wait.
// One access in flight; completion is a single-cycle mem_ready pulse, timeouts flag mem_err.
module mem_bus_interface #(
  parameter int unsigned ADDR_W  = 22,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] MEM_ADDRESS,
  input  logic [DATA_W-1:0] MEMDATA_OUT,
  input  logic              mem_cs,
  input  logic              mem_rd_wr,
  output logic [DATA_W-1:0] MEMDATA_IN,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  output logic              ext_we,
  output logic              ext_req,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ack
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              st_q, st_d;
  logic                armed_q, armed_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                req_q, req_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  always_comb begin
    st_d    = st_q;
    // A low mem_cs re-arms in any state; a held request cannot re-trigger.
    armed_d = armed_q | ~mem_cs;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = err_q;

    unique case (st_q)
      StIdle: begin
        if (mem_cs && armed_q) begin
          st_d    = StAccess;
          armed_d = 1'b0;
          addr_d  = MEM_ADDRESS;
          wdata_d = MEMDATA_OUT;
          we_d    = ~mem_rd_wr;
          rd_d    = mem_rd_wr;
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      StAccess: begin
        if (ext_ack) begin
          if (rd_q) rdata_d = ext_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          st_d    = StDone;
        end else if (cnt_q == CntLast) begin
          if (rd_q) rdata_d = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          st_d    = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        st_d = StIdle;
      end
      default: begin
        st_d = StIdle;
      end
    endcase

    busy_d = (st_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= StIdle;
      armed_q <= 1'b1;
      cnt_q   <= 8'd0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign MEMDATA_IN = rdata_q;
  assign mem_ready  = ready_q;
  assign mem_busy   = busy_q;
  assign mem_err    = err_q;
  assign ext_addr   = addr_q;
  assign ext_wdata  = wdata_q;
  assign ext_we     = we_q;
  assign ext_req    = req_q;

endmodule

// File: doc/mem_bus_interface.md
# mem_bus_interface

Bridges the processor's memory port to an external variable-latency memory with a req/ack handshake. It registers one processor access, holds the external request stable until acknowledged or timed out, returns read data, and signals completion with a one-cycle `mem_ready` pulse. It sits directly downstream of `processor`, consuming `MEM_ADDRESS`, `MEMDATA_OUT`, `mem_cs` and `mem_rd_wr`, and driving `MEMDATA_IN`.

## Interface
Clocking and reset (already decided): one clock, `clk`; reset `reset` is synchronous and active-high.

Parameters:
- `ADDR_W`, 22: address width, matching `MEM_ADDRESS`.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 15: maximum number of ACCESS cycles without `ext_ack`. Legal range is 1..255.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `MEM_ADDRESS`  in  ADDR_W  processor access address.
- `MEMDATA_OUT`  in  DATA_W  processor write data.
- `mem_cs`  in  1  processor request, level.
- `mem_rd_wr`  in  1  access type: 1 = read, 0 = write.
- `MEMDATA_IN`  out  DATA_W  read data returned to the processor.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_busy`  out  1  high in ACCESS and DONE.
- `mem_err`  out  1  last access timed out; sticky until the next accepted request.
- `ext_addr`  out  ADDR_W  external address.
- `ext_wdata`  out  DATA_W  external write data.
- `ext_we`  out  1  external write enable.
- `ext_req`  out  1  external request.
- `ext_rdata`  in  DATA_W  external read data, valid when `ext_ack`=1.
- `ext_ack`  in  1  external acknowledge.

## Operation
**FSM states:** IDLE, ACCESS, DONE. All outputs are registered.

**Armed flag**
- Set to 1 whenever `mem_cs`=0 is sampled.
- Cleared on request acceptance.
- Prevents a held `mem_cs` from re-triggering after completion.

**IDLE**
- Accepts a request when `mem_cs`=1 and armed=1.
- On acceptance:
  - capture `MEM_ADDRESS` into `ext_addr`;
  - capture `MEMDATA_OUT` into `ext_wdata`;
  - set `ext_we` = ~`mem_rd_wr`;
  - set `ext_req`=1, clear the wait counter, clear `mem_err`;
  - go to ACCESS.

**ACCESS**
- `ext_req`, `ext_addr`, `ext_wdata` and `ext_we` are held constant.
- If `ext_ack`=1:
  - on a read, latch `ext_rdata` into `MEMDATA_IN`;
  - drop `ext_req` and `ext_we`;
  - set `mem_ready`=1 and go to DONE.
- Else if the counter equals TIMEOUT-1:
  - drop `ext_req` and `ext_we`;
  - set `mem_err`=1 and `mem_ready`=1;
  - on a read, set `MEMDATA_IN` = 0;
  - go to DONE.
- Else increment the counter (8-bit, never wraps given the TIMEOUT range).

**DONE**
- Lasts exactly one cycle (the `mem_ready` pulse), then returns to IDLE.
- `mem_cs` is ignored in DONE.

**Boundary rules**
- `MEMDATA_IN` holds its last read value; writes and idle cycles never change it.
- `ext_ack` in IDLE or DONE is ignored.
- An ack arriving on the final TIMEOUT cycle wins: normal completion, `mem_err`=0.
- Changes on `MEM_ADDRESS`/`MEMDATA_OUT`/`mem_rd_wr` after acceptance have no effect on the current access.

## Timing
- **Reset:** state IDLE, armed=1, counter 0. Every output is 0: `MEMDATA_IN`, `mem_ready`, `mem_busy`, `mem_err`, `ext_addr`, `ext_wdata`, `ext_we`, `ext_req`.
- **Reset mid-access:** `ext_req` drops at the reset edge, no `mem_ready` is produced, and the access is abandoned.
- **Latency:** `mem_cs` is sampled at edge N, so `ext_req`=1 from edge N. An ack sampled at edge N+k (k≥1) gives `mem_ready`=1 for the cycle after edge N+k. The minimum request-to-ready latency is 2 edges.
- **Timeout:** `ext_req` is high for exactly TIMEOUT cycles. `mem_ready` and `mem_err` rise at edge N+TIMEOUT.
- **Back-to-back:** with `mem_cs` low for one cycle after `mem_ready`, the next request is accepted at the first IDLE edge where `mem_cs`=1. The minimum spacing between accept edges is 3 cycles.

## Test plan
- **Read, ack after 3 cycles:** reset, then read at addr 0x00_1234; memory acks on the 3rd ACCESS cycle with 0xCAFE_F00D. Require `ext_req` high for 3 cycles, `ext_we`=0, one `mem_ready` pulse, `MEMDATA_IN`=0xCAFE_F00D, `mem_err`=0.
- **Write, ack in 1st cycle:** write 0xA5A5_5A5A to 0x3F_FFFF, ack in the 1st ACCESS cycle. Require `ext_we`=1 and `ext_wdata`=0xA5A5_5A5A for exactly 1 cycle, `mem_ready` 2 edges after accept, `MEMDATA_IN` unchanged.
- **Timeout, then clean read:** read with no ack, TIMEOUT=15. Require `ext_req` high 15 cycles, `mem_err`=1, `MEMDATA_IN`=0. Then a successful read clears `mem_err` at accept.
- **Ack on last cycle:** ack on the 15th ACCESS cycle. Require normal completion with `mem_err`=0.
- **Held `mem_cs`:** hold `mem_cs`=1 for 20 cycles across completion. Require exactly one access. Drop `mem_cs` for 1 cycle and raise it again; require a second access accepted.
- **Reset mid-access:** assert `reset` during cycle 2 of ACCESS. Require all outputs 0 the next cycle, no `mem_ready`, and a late `ext_ack` ignored.
